// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for the MIPS-lite CPU.
// A Moore FSM walks each instruction through FETCH/DECODE/EXE/MEM/WB and drives
// every datapath select and write enable from the current state and the IR.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        PCWr,
  output logic        IRWr,
  output logic [1:0]  NPCOp,
  output logic        RegWr,
  output logic [1:0]  RegDst,
  output logic [1:0]  WDSel,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        MemWr,
  output logic [1:0]  EOp,
  output logic        done,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExe    = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Instruction decode
  logic [5:0] op, funct;
  logic       is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui;
  logic       is_lw, is_sw, is_beq, is_j, is_jal, is_unsup;
  logic       unused_instr;

  assign op       = instr[31:26];
  assign funct    = instr[5:0];
  assign is_rtype = (op == 6'b000000);
  assign is_addu  = is_rtype && (funct == 6'b100001);
  assign is_subu  = is_rtype && (funct == 6'b100011);
  assign is_jr    = is_rtype && (funct == 6'b001000);
  assign is_ori   = (op == 6'b001101);
  assign is_lui   = (op == 6'b001111);
  assign is_lw    = (op == 6'b100011);
  assign is_sw    = (op == 6'b101011);
  assign is_beq   = (op == 6'b000100);
  assign is_j     = (op == 6'b000010);
  assign is_jal   = (op == 6'b000011);
  assign is_unsup = !(is_addu || is_subu || is_jr || is_ori || is_lui ||
                      is_lw || is_sw || is_beq || is_j || is_jal);

  // Register, immediate and shamt fields are datapath concerns only.
  assign unused_instr = ^instr[25:6];

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection: short instructions leave from DECODE, beq from EXE,
  // sw from MEM, everything else from WB.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        if (is_j || is_jal || is_jr || is_unsup) begin
          state_d = StFetch;
        end else begin
          state_d = StExe;
        end
      end
      StExe: begin
        if (is_lw || is_sw) begin
          state_d = StMem;
        end else if (is_beq) begin
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StMem:    state_d = is_lw ? StWb : StFetch;
      StWb:     state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Outputs: selects held for the whole instruction after FETCH, enables per state,
  // and reset overrides everything to zero.
  always_comb begin
    PCWr   = 1'b0;
    IRWr   = 1'b0;
    RegWr  = 1'b0;
    MemWr  = 1'b0;
    done   = 1'b0;
    NPCOp  = 2'b00;
    RegDst = 2'b00;
    WDSel  = 2'b00;
    ALUSrc = 1'b0;
    ALUOp  = 2'b00;
    EOp    = 2'b00;

    if (!reset && (state_q inside {StDecode, StExe, StMem, StWb})) begin
      if (is_addu || is_subu) RegDst = 2'b01;
      if (is_jal)             RegDst = 2'b10;
      if (is_lw)              WDSel  = 2'b01;
      if (is_jal)             WDSel  = 2'b10;
      if (is_ori || is_lui || is_lw || is_sw) ALUSrc = 1'b1;
      if (is_subu || is_beq)  ALUOp  = 2'b01;
      if (is_ori || is_lui)   ALUOp  = 2'b10;
      if (is_ori)             EOp    = 2'b01;
      if (is_lui)             EOp    = 2'b10;
      if (is_beq)             EOp    = 2'b11;
      if (is_beq)             NPCOp  = 2'b01;
      if (is_j || is_jal)     NPCOp  = 2'b10;
      if (is_jr)              NPCOp  = 2'b11;
    end

    case (state_q)
      StFetch: begin
        IRWr = 1'b1;
        PCWr = 1'b1;
      end
      StDecode: begin
        if (is_j || is_jal || is_jr) PCWr = 1'b1;
        if (is_jal)                  RegWr = 1'b1;
        if (is_j || is_jal || is_jr || is_unsup) done = 1'b1;
      end
      StExe: begin
        if (is_beq) begin
          PCWr = zero;
          done = 1'b1;
        end
      end
      StMem: begin
        if (is_sw) begin
          MemWr = 1'b1;
          done  = 1'b1;
        end
      end
      StWb: begin
        RegWr = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase

    if (reset) begin
      PCWr  = 1'b0;
      IRWr  = 1'b0;
      RegWr = 1'b0;
      MemWr = 1'b0;
      done  = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS-lite CPU. Moore-style FSM that walks each instruction through FETCH/DECODE/EXE/MEM/WB and drives every datapath select and write enable. This includes the 2-bit EOp code of the immediate extender, so the extender, ALU, register file and data memory are shared across cycles. The block sits between the instruction register and the datapath muxes. It owns all sequencing; the datapath holds no control state.

## Interface
Parameters: none.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instr  in  32  IR contents; stable from DECODE until the instruction ends.
- zero  in  1  ALU equality flag; valid in EXE.
- PCWr  out  1  PC write enable.
- IRWr  out  1  IR write enable.
- NPCOp  out  2  next-PC select: 00 PC+4, 01 branch (PC+ext), 10 j/jal target, 11 rs (jr).
- RegWr  out  1  register-file write enable.
- RegDst  out  2  write-register select: 00 rt, 01 rd, 10 $31.
- WDSel  out  2  write-data select: 00 ALU, 01 memory, 10 PC.
- ALUSrc  out  1  ALU B operand: 0 rt, 1 extender output.
- ALUOp  out  2  ALU function: 00 add, 01 sub, 10 or.
- MemWr  out  1  data-memory write enable.
- EOp  out  2  extender mode: 00 sign, 01 zero, 10 imm<<16, 11 sign, then <<2.
- done  out  1  one-cycle pulse on the last cycle of each instruction.
- state  out  3  current state, for debug.

## Operation
- Supported instructions:
  - addu: R-type, funct 100001.
  - subu: R-type, funct 100011.
  - jr: R-type, funct 001000.
  - ori: opcode 001101.
  - lui: opcode 001111.
  - lw: opcode 100011.
  - sw: opcode 101011.
  - beq: opcode 000100.
  - j: opcode 000010.
  - jal: opcode 000011.
  - Anything else, including nop/sll, is unsupported.
- State encoding: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Encodings 5–7 go to FETCH on the next edge, with all enables 0.
- FETCH: IRWr=1, PCWr=1, NPCOp=00. Next state: DECODE.
- DECODE:
  - j: PCWr=1, NPCOp=10, done=1. Next state: FETCH.
  - jal: same as j, plus RegWr=1, RegDst=10, WDSel=10. The PC already holds PC+4, and that value is written. Next state: FETCH.
  - jr: PCWr=1, NPCOp=11, done=1. Next state: FETCH.
  - Unsupported: all enables 0, done=1. Next state: FETCH.
  - All other instructions: no enables asserted. Next state: EXE.
- EXE:
  - addu/subu: ALUSrc=0, ALUOp 00/01. Next state: WB.
  - ori: ALUSrc=1, ALUOp=10, EOp=01. Next state: WB.
  - lui: ALUSrc=1, ALUOp=10, EOp=10. rs is $0, so the ALU passes the extender output. Next state: WB.
  - lw/sw: ALUSrc=1, ALUOp=00, EOp=00. Next state: MEM.
  - beq: ALUSrc=0, ALUOp=01, EOp=11, NPCOp=01, PCWr=zero, done=1. Next state: FETCH.
- MEM:
  - sw: MemWr=1, done=1. Next state: FETCH.
  - lw: no write. Next state: WB.
- WB:
  - RegWr=1, done=1. Next state: FETCH.
  - RegDst: 01 for R-type, 00 otherwise.
  - WDSel: 01 for lw, 00 otherwise.
- Select outputs (EOp, ALUSrc, ALUOp, RegDst, WDSel, NPCOp) hold their instruction-specific value in every state from DECODE to the instruction's end. This keeps mux paths stable across the sequence.
- Enables (PCWr, IRWr, RegWr, MemWr, done) are asserted only in the states listed above and are 0 otherwise.

## Timing
- Next state is registered and updates on the rising edge of clk. Outputs are combinational from state and instr.
- Cycles per instruction:
  - j, jal, jr, unsupported: 2.
  - beq: 3, taken or not.
  - sw, addu, subu, ori, lui: 4.
  - lw: 5.
- While reset=1:
  - state forced to FETCH asynchronously.
  - All enables and done forced to 0, overriding the FETCH decode.
  - All selects at 00/0.
- First FETCH action (IRWr/PCWr=1) occurs in the first cycle after reset deasserts.
- Reset mid-instruction: a pending RegWr or MemWr is never issued. The PC is not written again until the post-reset FETCH.
- At most one of RegWr or MemWr is high in any cycle. PCWr and RegWr are both high only for jal in DECODE.
- zero is sampled only in EXE of beq.

## Test plan
- Reset held 3 cycles mid-WB of addu: all enables and done stay 0 throughout. state=0. The cycle after release shows IRWr=1 and PCWr=1.
- ori $1,$0,0xFFFF: EOp=01 in DECODE/EXE/WB. RegWr=1 with RegDst=00 only in cycle 4. done pulses once in cycle 4.
- lui $2,0x1234, then lw $3,4($0): lui shows EOp=10 over 4 cycles. lw shows EOp=00, MEM with MemWr=0, then WB with WDSel=01 and RegWr=1. Total 5 cycles.
- beq with zero=1, then beq with zero=0: both use EOp=11 and NPCOp=01 in EXE. PCWr=1 for the first and 0 for the second. Each takes 3 cycles.
- jal 0x0C00 then jr $31: jal asserts PCWr, RegWr, RegDst=10 and WDSel=10 together in DECODE. jr gives NPCOp=11. Each takes 2 cycles.
- instr=0x00000000 (sll, unsupported), then sw: the first returns to FETCH after 2 cycles with no writes. sw gives MemWr=1 only in cycle 4, and RegWr is never asserted.
